gate_bank_arbiter: RTL and testbench

- Shares one combinational 3-input gate bank between two requesters.
- The bank has 3 inputs and a 9-bit result: NOT, AND, NAND, OR, NOR, XOR, XNOR, 3-input XNOR and 3-input AND.
- The block arbitrates round-robin, latches the winner's operands, drives the bank, registers its 9-bit result and returns it with a done pulse.
- It sits between the requester logic and the bank instance, which is external to this block.

---
 rtl/gate_bank_arbiter.sv | 175 +++++++++++++++++
 tb/tb_gate_bank_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_bank_arbiter.sv
// gate_bank_arbiter: round-robin share of one external 3-input gate bank between two requesters.
// Latency: req sampled at edge 0, gnt during ISSUE, done + rsp_data after edge 1, done drops at edge 2.
// Backpressure: none queued; a requester holds req until it sees gnt/done and is served on a later IDLE.
// Optional build macro GATE_BANK_SWEEP_EN adds an 8-cycle self-sweep of the bank (sweep_* ports).
module gate_bank_arbiter #(
  parameter int OP_W  = 3,
  parameter int RES_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [OP_W-1:0]  op0,
  input  logic [OP_W-1:0]  op1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [RES_W-1:0] rsp_data,
  output logic [OP_W-1:0]  bank_in,
  input  logic [RES_W-1:0] bank_result
`ifdef GATE_BANK_SWEEP_EN
  ,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic [RES_W-1:0] sweep_sig
`endif
);

  // SWEEP encoding is always reserved so the state register width is build-independent.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    SWEEP   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [1:0]         done_q, done_d;
  logic [RES_W-1:0]   rsp_q, rsp_d;
  logic [OP_W-1:0]    opq_q, opq_d;
  logic               last_q, last_d;
  logic               win;

`ifdef GATE_BANK_SWEEP_EN
  logic [OP_W-1:0]    cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [RES_W-1:0]   sig_q, sig_d;
`endif

  // Round-robin pick: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    win = 1'b0;
    if (req == 2'b11) begin
      win = ~last_q;
    end else begin
      win = req[1];
    end
  end

  // State register and all registered outputs; reset discards any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      rsp_q   <= '0;
      opq_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rsp_q   <= rsp_d;
      opq_q   <= opq_d;
      last_q  <= last_d;
    end
  end

`ifdef GATE_BANK_SWEEP_EN
  // Sweep counter, busy flag and XOR signature registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      sig_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      sig_q  <= sig_d;
    end
  end
`endif

  // Next-state and next-output logic for IDLE -> ISSUE -> CAPTURE -> IDLE (and SWEEP).
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = done_q;
    rsp_d   = rsp_q;
    opq_d   = opq_q;
    last_d  = last_q;
`ifdef GATE_BANK_SWEEP_EN
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    sig_d   = sig_q;
`endif
    case (state_q)
      IDLE: begin
        gnt_d  = '0;
        done_d = '0;
`ifdef GATE_BANK_SWEEP_EN
        // A sweep request outranks any pending requester.
        if (sweep_start) begin
          cnt_d   = '0;
          sig_d   = '0;
          busy_d  = 1'b1;
          state_d = SWEEP;
        end else
`endif
        if (|req) begin
          // Operands are captured here so the requester may change them after the grant.
          opq_d   = win ? op1 : op0;
          gnt_d   = win ? 2'b10 : 2'b01;
          last_d  = win;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Bank is driven from opq this cycle; capture its result and signal the winner.
        rsp_d   = bank_result;
        done_d  = gnt_q;
        gnt_d   = '0;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        done_d  = '0;
        state_d = IDLE;
      end
`ifdef GATE_BANK_SWEEP_EN
      SWEEP: begin
        sig_d = sig_q ^ bank_result;
        cnt_d = cnt_q + OP_W'(1);
        if (cnt_q == {OP_W{1'b1}}) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
`endif
      default: begin
        gnt_d   = '0;
        done_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Bank input: latched operands, or the sweep counter while sweeping.
  always_comb begin
    bank_in = opq_q;
`ifdef GATE_BANK_SWEEP_EN
    if (state_q == SWEEP) begin
      bank_in = cnt_q;
    end
`endif
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign rsp_data = rsp_q;

`ifdef GATE_BANK_SWEEP_EN
  assign sweep_busy = busy_q;
  assign sweep_sig  = sig_q;
`endif

endmodule

// File: tb/tb_gate_bank_arbiter.sv
// Bench for gate_bank_arbiter: models the external gate bank, drives directed requests and
// checks grants/completions through expectation queues drained by an independent monitor.
module tb_gate_bank_arbiter;
  localparam int OP_W  = 3;
  localparam int RES_W = 9;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req;
  logic [OP_W-1:0]  op0, op1;
  logic [1:0]       gnt, done;
  logic [RES_W-1:0] rsp_data;
  logic [OP_W-1:0]  bank_in;
  logic [RES_W-1:0] bank_result;
`ifdef GATE_BANK_SWEEP_EN
  logic             sweep_start;
  logic             sweep_busy;
  logic [RES_W-1:0] sweep_sig;
`endif

  gate_bank_arbiter #(.OP_W(OP_W), .RES_W(RES_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op0(op0), .op1(op1),
    .gnt(gnt), .done(done), .rsp_data(rsp_data),
    .bank_in(bank_in), .bank_result(bank_result)
`ifdef GATE_BANK_SWEEP_EN
    , .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_sig(sweep_sig)
`endif
  );

  always #5 clk = ~clk;

  // External gate bank: bit0 NOT a, AND, NAND, OR, NOR, XOR, XNOR, 3-in XNOR, 3-in AND.
  function automatic logic [8:0] bank_model(input logic [2:0] x);
    logic a, b, c;
    logic [8:0] r;
    a = x[0]; b = x[1]; c = x[2];
    r[0] = ~a;
    r[1] = a & b;
    r[2] = ~(a & b);
    r[3] = a | b;
    r[4] = ~(a | b);
    r[5] = a ^ b;
    r[6] = ~(a ^ b);
    r[7] = ~(a ^ b ^ c);
    r[8] = a & b & c;
    return r;
  endfunction

  always_comb bank_result = bank_model(bank_in);

  typedef struct packed {
    logic [1:0] dn;
    logic [8:0] data;
  } rsp_t;

  rsp_t       sb_q[$];
  logic [1:0] gnt_q[$];
  int         done_cyc[$];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pops an expectation whenever the DUT shows a grant or a completion.
  always @(negedge clk) begin : monitor
    rsp_t       r;
    logic [1:0] e;
    if (rst_n === 1'b1 && gnt !== 2'b00) begin
      if (gnt_q.size() == 0) begin
        check("gnt_unexpected", 32'(gnt), 32'h0);
      end else begin
        e = gnt_q.pop_front();
        check("gnt", 32'(gnt), 32'(e));
      end
    end
    if (rst_n === 1'b1 && done !== 2'b00) begin
      done_cyc.push_back(cyc);
      if (sb_q.size() == 0) begin
        check("done_unexpected", 32'(done), 32'h0);
      end else begin
        r = sb_q.pop_front();
        check("done", 32'(done), 32'(r.dn));
        check("rsp_data", 32'(rsp_data), 32'(r.data));
      end
    end
  end

  task automatic expect_txn(input bit k, input logic [8:0] res);
    gnt_q.push_back(k ? 2'b10 : 2'b01);
    sb_q.push_back({(k ? 2'b10 : 2'b01), res});
  endtask

  // Waits (bounded) on a negedge where gnt[k] is high.
  task automatic wait_gnt(input bit k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt[k] !== 1'b1 && n < 20);
    check("gnt_wait", 32'(gnt[k]), 32'h1);
  endtask

  task automatic do_single(input bit k, input logic [2:0] op, input logic [8:0] res);
    expect_txn(k, res);
    @(posedge clk); #1;
    if (k) op1 = op; else op0 = op;
    req[k] = 1'b1;
    wait_gnt(k);
    req[k] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rsp_hold", 32'(rsp_data), 32'(res));
  endtask

  // Both requesters held for n transactions; grants must alternate starting with 0.
  task automatic contend(input int n);
    for (int i = 0; i < n; i++) begin
      if (i % 2 == 0) expect_txn(1'b0, 9'h0CA);
      else            expect_txn(1'b1, 9'h0D5);
    end
    done_cyc.delete();
    @(posedge clk); #1;
    op0 = 3'b011;
    op1 = 3'b000;
    req = 2'b11;
    repeat (3 * n) @(posedge clk);
    #1;
    req = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("done_count", 32'(done_cyc.size()), 32'(n));
    for (int i = 1; i < done_cyc.size(); i++) begin
      check("done_spacing", 32'(done_cyc[i] - done_cyc[i-1]), 32'd3);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n_done;
    int busy_cyc;
    int gnt_bad;
    rst_n = 1'b0;
    req   = 2'b00;
    op0   = '0;
    op1   = '0;
`ifdef GATE_BANK_SWEEP_EN
    sweep_start = 1'b0;
`endif
    #3;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    check("rst_bank_in", 32'(bank_in), 32'h0);
`ifdef GATE_BANK_SWEEP_EN
    check("rst_sweep_busy", 32'(sweep_busy), 32'h0);
    check("rst_sweep_sig", 32'(sweep_sig), 32'h0);
`endif
    #9 rst_n = 1'b1;

    // Single requests on each side.
    do_single(1'b0, 3'b011, 9'h0CA);
    do_single(1'b1, 3'b000, 9'h0D5);

    // Contention: 12 cycles, four alternating transactions.
    contend(4);

    // Operands changed during the grant cycle must not affect the result.
    expect_txn(1'b0, 9'h0CA);
    @(posedge clk); #1;
    op0 = 3'b011;
    req = 2'b01;
    wait_gnt(1'b0);
    op0 = 3'b111;
    req = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("latched_rsp", 32'(rsp_data), 32'h0CA);

    // Reset in the middle of ISSUE: outputs clear at once, no done afterwards.
    expect_txn(1'b1, 9'h0D5);
    @(posedge clk); #1;
    op1 = 3'b000;
    req = 2'b10;
    wait_gnt(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    gnt_q.delete();
    req = 2'b00;
    n_done = done_cyc.size();
    check("abort_gnt", 32'(gnt), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_rsp_data", 32'(rsp_data), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cyc.size()), 32'(n_done));

    // Tie right after reset goes to requester 0 first.
    contend(2);

`ifdef GATE_BANK_SWEEP_EN
    // Sweep outranks a pending request; request served once the sweep ends.
    expect_txn(1'b0, 9'h0CA);
    @(posedge clk); #1;
    sweep_start = 1'b1;
    op0 = 3'b011;
    req = 2'b01;
    @(posedge clk); #1;
    sweep_start = 1'b0;
    busy_cyc = 0;
    gnt_bad  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sweep_busy !== 1'b1) break;
      busy_cyc++;
      if (gnt !== 2'b00) gnt_bad++;
    end
    check("sweep_busy_cycles", 32'(busy_cyc), 32'd8);
    check("sweep_no_gnt", 32'(gnt_bad), 32'd0);
    check("sweep_sig", 32'(sweep_sig), 32'h100);
    wait_gnt(1'b0);
    req = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("post_sweep_rsp", 32'(rsp_data), 32'h0CA);
`endif

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    check("gnt_drain", 32'(gnt_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
